// File: rtl/pcm_pkg.sv
// rtl/pcm_pkg.sv - shared PCM sample width, period width and midscale constants
package pcm_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int PER_W_DEF  = 9;
  localparam int DEPTH_DEF  = 4;
  localparam logic [7:0] MIDSCALE = 8'h80;
endpackage

// File: rtl/pcm_sample_pacer_if.sv
// rtl/pcm_sample_pacer_if.sv - valid/ready sample stream from the bytebeat generator
interface pcm_sample_pacer_if
  import pcm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] in_data;
  logic              in_vld;
  logic              in_rdy;

  modport master (output in_data, output in_vld, input in_rdy);
  modport slave  (input in_data, input in_vld, output in_rdy);
endinterface

// File: rtl/pcm_sync_fifo.sv
// rtl/pcm_sync_fifo.sv - single-clock sample FIFO with occupancy count
module pcm_sync_fifo
  import pcm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/pcm_sample_pacer.sv
// rtl/pcm_sample_pacer.sv - releases buffered PCM samples at a programmable tick rate
module pcm_sample_pacer
  import pcm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PER_W  = PER_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  pcm_sample_pacer_if.slave  s_in,
  input  logic [PER_W-1:0]   period,
  output logic [DATA_W-1:0]  sample,
  output logic               sample_stb,
  output logic [7:0]         underrun_cnt
);
  logic [PER_W-1:0]  r_tick_cnt;
  logic [DATA_W-1:0] r_sample;
  logic              r_stb;
  logic [7:0]        r_underrun;
  logic              w_tick;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;

  // >= rather than == so a period lowered below the running count ticks at once
  assign w_tick      = (r_tick_cnt >= period);
  assign w_pop       = w_tick && !w_empty;
  assign s_in.in_rdy = !w_full;

  pcm_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (s_in.in_vld),
    .i_data  (s_in.in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_sample   <= DATA_W'(MIDSCALE);
      r_stb      <= 1'b0;
      r_underrun <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_stb      <= w_pop;
      if (w_pop) r_sample <= w_head;
      if (w_tick && w_empty && (r_underrun != 8'hFF)) r_underrun <= r_underrun + 1'b1;
    end
  end

  assign sample       = r_sample;
  assign sample_stb   = r_stb;
  assign underrun_cnt = r_underrun;
endmodule

// File: tb/tb_pcm_sample_pacer.sv
// tb/tb_pcm_sample_pacer.sv - self-checking bench for pcm_sample_pacer
module tb_pcm_sample_pacer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] period = '0;
  logic [7:0] sample;
  logic       sample_stb;
  logic [7:0] underrun_cnt;
  int         n_checks = 0;
  int         n_fail = 0;

  pcm_sample_pacer_if #(.DATA_W(8)) bus ();

  pcm_sample_pacer #(.DATA_W(8), .DEPTH(DEPTH), .PER_W(9)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_in         (bus),
    .period       (period),
    .sample       (sample),
    .sample_stb   (sample_stb),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  // Reference: a sample queue drained once every (period+1) cycles
  byte unsigned m_q[$];
  logic [7:0]   m_sample = 8'h80;
  logic         m_stb = 1'b0;
  logic [7:0]   m_under = 8'h00;
  int           m_since = 0;
  bit           m_tick;
  bit           m_push;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_sample = 8'h80;
      m_stb    = 1'b0;
      m_under  = 8'h00;
      m_since  = 0;
    end else begin
      m_tick = (m_since >= int'(period));
      m_push = bus.in_vld && (m_q.size() != DEPTH);
      m_stb  = 1'b0;
      if (m_tick) begin
        if (m_q.size() != 0) begin
          m_sample = m_q.pop_front();
          m_stb    = 1'b1;
        end else if (m_under != 8'hFF) begin
          m_under = m_under + 8'd1;
        end
      end
      if (m_push) m_q.push_back(bus.in_data);
      m_since = m_tick ? 0 : m_since + 1;
    end
  end

  task automatic apply_reset(input logic [8:0] per);
    @(negedge clk);
    reset = 1'b1;
    bus.in_vld = 1'b0;
    period = per;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    bus.in_vld = 1'b0;
    period = 9'd5;
    repeat (3) @(negedge clk);
    n_checks++; if (sample !== 8'h80) begin n_fail++; $display("FAIL reset_sample: got %h expected 80", sample); end
    n_checks++; if (sample_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b expected 0", sample_stb); end
    n_checks++; if (underrun_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_underrun: got %h expected 00", underrun_cnt); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b expected 1", bus.in_rdy); end
  endtask

  task automatic test_pacing;
    byte unsigned got[$];
    int stb_at[$];
    apply_reset(9'd3);
    bus.in_vld = 1'b1;
    bus.in_data = 8'h11;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (sample !== m_sample || sample_stb !== m_stb) begin
        n_fail++; $display("FAIL pacing_model k=%0d: got %h/%b expected %h/%b", k, sample, sample_stb, m_sample, m_stb);
      end
      if (sample_stb === 1'b1) begin got.push_back(sample); stb_at.push_back(k); end
      if (k == 0) bus.in_data = 8'h22;
      if (k == 1) bus.in_data = 8'h33;
      if (k == 2) bus.in_vld = 1'b0;
    end
    n_checks++;
    if (got.size() != 3) begin
      n_fail++; $display("FAIL pacing_count: got %0d strobes expected 3", got.size());
    end else begin
      n_checks++; if (got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin
        n_fail++; $display("FAIL pacing_seq: got %h %h %h expected 11 22 33", got[0], got[1], got[2]);
      end
      n_checks++; if (stb_at[0] != 3 || stb_at[1] - stb_at[0] != 4 || stb_at[2] - stb_at[1] != 4) begin
        n_fail++; $display("FAIL pacing_spacing: got %0d %0d %0d expected 3 7 11", stb_at[0], stb_at[1], stb_at[2]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] nd;
    logic [7:0] exp_d;
    int pushes = 0;
    int first_block = -1;
    int n_stb = 0;
    bit xfer;
    apply_reset(9'd15);
    nd = 8'($urandom_range(0, 255));
    exp_d = nd;
    bus.in_vld = 1'b1;
    bus.in_data = nd;
    for (int k = 0; k < 80; k++) begin
      xfer = bus.in_vld && bus.in_rdy;
      @(negedge clk);
      if (xfer) begin pushes++; nd = nd + 8'd1; bus.in_data = nd; end
      n_checks++;
      if (bus.in_rdy !== (m_q.size() != DEPTH)) begin
        n_fail++; $display("FAIL bp_rdy k=%0d: got %b expected %b", k, bus.in_rdy, m_q.size() != DEPTH);
      end
      if (bus.in_rdy === 1'b0 && first_block < 0) first_block = pushes;
      if (sample_stb === 1'b1) begin
        n_stb++;
        n_checks++;
        if (sample !== exp_d) begin n_fail++; $display("FAIL bp_order: got %h expected %h", sample, exp_d); end
        exp_d = exp_d + 8'd1;
      end
    end
    n_checks++; if (first_block != 4) begin n_fail++; $display("FAIL bp_first_block: got %0d expected 4", first_block); end
    n_checks++; if (n_stb != 5) begin n_fail++; $display("FAIL bp_pops: got %0d expected 5", n_stb); end
    n_checks++; if (pushes != 8) begin n_fail++; $display("FAIL bp_pushes: got %0d expected 8", pushes); end
    bus.in_vld = 1'b0;
  endtask

  task automatic test_underrun;
    int n_stb = 0;
    apply_reset(9'd0);
    bus.in_vld = 1'b1;
    bus.in_data = 8'h5A;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 0) bus.in_vld = 1'b0;
      if (sample_stb === 1'b1) n_stb++;
      n_checks++;
      if (underrun_cnt !== m_under || sample !== m_sample) begin
        n_fail++; $display("FAIL underrun_model k=%0d: got %h/%h expected %h/%h", k, underrun_cnt, sample, m_under, m_sample);
      end
    end
    n_checks++; if (sample !== 8'h5A) begin n_fail++; $display("FAIL underrun_hold: got %h expected 5a", sample); end
    n_checks++; if (underrun_cnt !== 8'hFF) begin n_fail++; $display("FAIL underrun_sat: got %h expected ff", underrun_cnt); end
    n_checks++; if (n_stb != 1) begin n_fail++; $display("FAIL underrun_stb: got %0d expected 1", n_stb); end
  endtask

  task automatic test_period_change;
    byte unsigned pushed[$];
    int stb_at[$];
    int chg = 0;
    apply_reset(9'd100);
    bus.in_vld = 1'b1;
    bus.in_data = 8'($urandom);
    pushed.push_back(bus.in_data);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sample_stb === 1'b1) begin
        stb_at.push_back(k);
        n_checks++;
        if (pushed.size() == 0) begin
          n_fail++; $display("FAIL pchg_extra: got %h expected no strobe", sample);
        end else if (sample !== pushed[0]) begin
          n_fail++; $display("FAIL pchg_data: got %h expected %h", sample, pushed[0]);
        end
        if (pushed.size() != 0) void'(pushed.pop_front());
      end
      if (k < 3) begin bus.in_data = 8'($urandom); pushed.push_back(bus.in_data); end
      if (k == 3) bus.in_vld = 1'b0;
      if (k == 49) begin period = 9'd10; chg = k; end
    end
    n_checks++;
    if (stb_at.size() != 4) begin
      n_fail++; $display("FAIL pchg_count: got %0d expected 4", stb_at.size());
    end else begin
      n_checks++; if (stb_at[0] != chg + 1) begin
        n_fail++; $display("FAIL pchg_first: got %0d expected %0d", stb_at[0], chg + 1);
      end
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (stb_at[i] - stb_at[i-1] != 11) begin
          n_fail++; $display("FAIL pchg_spacing %0d: got %0d expected 11", i, stb_at[i] - stb_at[i-1]);
        end
      end
    end
  endtask

  task automatic test_midop_reset;
    int n_stb = 0;
    apply_reset(9'd20);
    bus.in_vld = 1'b1;
    bus.in_data = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k < 2) bus.in_data = 8'($urandom);
      if (k == 2) begin bus.in_vld = 1'b0; reset = 1'b1; end
    end
    @(negedge clk);
    reset = 1'b0;
    period = 9'd2;
    n_checks++; if (sample !== 8'h80 || sample_stb !== 1'b0 || underrun_cnt !== 8'h00) begin
      n_fail++; $display("FAIL midrst_state: got %h/%b/%h expected 80/0/00", sample, sample_stb, underrun_cnt);
    end
    n_checks++; if (bus.in_rdy !== 1'b1) begin n_fail++; $display("FAIL midrst_rdy: got %b expected 1", bus.in_rdy); end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (sample_stb === 1'b1) n_stb++;
      n_checks++;
      if (underrun_cnt !== m_under || sample !== 8'h80) begin
        n_fail++; $display("FAIL midrst_model k=%0d: got %h/%h expected %h/80", k, underrun_cnt, sample, m_under);
      end
    end
    n_checks++; if (n_stb != 0) begin n_fail++; $display("FAIL midrst_stale: got %0d strobes expected 0", n_stb); end
  endtask

  task automatic test_random;
    apply_reset(9'($urandom_range(0, 5)));
    for (int k = 0; k < 600; k++) begin
      bus.in_vld  = ($urandom_range(0, 99) < 60);
      bus.in_data = 8'($urandom);
      if ($urandom_range(0, 99) < 5) period = 9'($urandom_range(0, 6));
      reset = ($urandom_range(0, 99) < 1);
      @(negedge clk);
      n_checks++;
      if (sample !== m_sample || sample_stb !== m_stb || underrun_cnt !== m_under ||
          bus.in_rdy !== (m_q.size() != DEPTH)) begin
        n_fail++;
        $display("FAIL random k=%0d: got %h/%b/%h/%b expected %h/%b/%h/%b", k, sample, sample_stb, underrun_cnt,
                 bus.in_rdy, m_sample, m_stb, m_under, m_q.size() != DEPTH);
      end
    end
    reset = 1'b0;
    bus.in_vld = 1'b0;
  endtask

  initial begin
    bus.in_vld = 1'b0;
    bus.in_data = 8'h00;
    test_reset();
    test_pacing();
    test_back_to_back();
    test_underrun();
    test_period_change();
    test_midop_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
